// File: rtl/rv32i_id_stage.sv
// RV32I decode/issue stage: OP/OP-IMM decode, 32-entry register file, pending-write scoreboard.
// Optional feature: define ID_BYPASS_EN to forward same-cycle writebacks into operand reads.

package rv32i_id_pkg;
    typedef enum logic [2:0] {
        ADD_OP = 3'd0,
        SUB_OP = 3'd1,
        SLL_OP = 3'd2,
        XOR_OP = 3'd3,
        SRL_OP = 3'd4,
        SRA_OP = 3'd5,
        OR_OP  = 3'd6,
        AND_OP = 3'd7
    } alu_op_t;
endpackage

module rv32i_id_stage
    import rv32i_id_pkg::*;
#(
    parameter int unsigned DPW = 32
) (
    input  logic           clk,
    input  logic           arst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [31:0]    in_instr,
    input  logic           wb_en,
    input  logic [4:0]     wb_addr,
    input  logic [DPW-1:0] wb_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [DPW-1:0] opr_a,
    output logic [DPW-1:0] opr_b,
    output alu_op_t        opcode,
    output logic [4:0]     rd_addr,
    output logic           rd_we,
    output logic           illegal
);

    localparam int unsigned NREG     = 32;
    localparam logic [6:0]  OPC_OP   = 7'b0110011;
    localparam logic [6:0]  OPC_OPI  = 7'b0010011;
`ifdef ID_BYPASS_EN
    localparam bit          BYPASS   = 1'b1;
`else
    localparam bit          BYPASS   = 1'b0;
`endif

    logic [DPW-1:0]  rf [NREG];
    logic [NREG-1:0] pending;

    logic [6:0] opc;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    logic [6:0] f7;

    assign opc = in_instr[6:0];
    assign rd  = in_instr[11:7];
    assign f3  = in_instr[14:12];
    assign rs1 = in_instr[19:15];
    assign rs2 = in_instr[24:20];
    assign f7  = in_instr[31:25];

    logic     dec_legal, dec_is_op, dec_we;
    alu_op_t  dec_op;
    logic [DPW-1:0] imm_val;

    // Instruction decode; anything not matched stays illegal with ADD_OP.
    always_comb begin
        dec_legal = 1'b0;
        dec_is_op = 1'b0;
        dec_op    = ADD_OP;
        imm_val   = {{(DPW-12){in_instr[31]}}, in_instr[31:20]};
        if (opc == OPC_OP) begin
            dec_is_op = 1'b1;
            case (f3)
                3'b000: begin
                    dec_legal = (f7 == 7'h00) || (f7 == 7'h20);
                    dec_op    = (f7 == 7'h20) ? SUB_OP : ADD_OP;
                end
                3'b001: begin dec_legal = (f7 == 7'h00); dec_op = SLL_OP; end
                3'b100: begin dec_legal = (f7 == 7'h00); dec_op = XOR_OP; end
                3'b101: begin
                    dec_legal = (f7 == 7'h00) || (f7 == 7'h20);
                    dec_op    = (f7 == 7'h20) ? SRA_OP : SRL_OP;
                end
                3'b110: begin dec_legal = (f7 == 7'h00); dec_op = OR_OP; end
                3'b111: begin dec_legal = (f7 == 7'h00); dec_op = AND_OP; end
                default: dec_legal = 1'b0;
            endcase
        end else if (opc == OPC_OPI) begin
            case (f3)
                3'b000: begin dec_legal = 1'b1; dec_op = ADD_OP; end
                3'b001: begin
                    dec_legal = (f7 == 7'h00);
                    dec_op    = SLL_OP;
                    imm_val   = DPW'(in_instr[24:20]);
                end
                3'b100: begin dec_legal = 1'b1; dec_op = XOR_OP; end
                3'b101: begin
                    dec_legal = (f7 == 7'h00) || (f7 == 7'h20);
                    dec_op    = in_instr[30] ? SRA_OP : SRL_OP;
                    imm_val   = DPW'(in_instr[24:20]);
                end
                3'b110: begin dec_legal = 1'b1; dec_op = OR_OP; end
                3'b111: begin dec_legal = 1'b1; dec_op = AND_OP; end
                default: dec_legal = 1'b0;
            endcase
        end
        dec_we = dec_legal && (rd != 5'd0);
    end

    logic fwd1, fwd2;
    logic [DPW-1:0] rs1_val, rs2_val;
    logic hazard, accept;

    // Register read with optional same-cycle writeback forwarding.
    assign fwd1    = BYPASS && wb_en && (wb_addr == rs1);
    assign fwd2    = BYPASS && wb_en && (wb_addr == rs2);
    assign rs1_val = (rs1 == 5'd0) ? '0 : (fwd1 ? wb_data : rf[rs1]);
    assign rs2_val = (rs2 == 5'd0) ? '0 : (fwd2 ? wb_data : rf[rs2]);

    assign hazard   = dec_legal && ((pending[rs1] && !fwd1) ||
                                    (dec_is_op && pending[rs2] && !fwd2));
    assign in_ready = !arst && (!out_valid || out_ready) && !hazard;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int i = 0; i < int'(NREG); i++) rf[i] <= '0;
        end else if (wb_en && (wb_addr != 5'd0)) begin
            rf[wb_addr] <= wb_data;
        end
    end

    // Scoreboard: issue-set takes priority over writeback-clear.
    logic [NREG-1:0] sb_set, sb_clr;
    assign sb_set = (accept && dec_we) ? (NREG'(1) << rd) : '0;
    assign sb_clr = wb_en ? (NREG'(1) << wb_addr) : '0;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) pending <= '0;
        else      pending <= (pending & ~sb_clr) | sb_set;
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            out_valid <= 1'b0;
            opr_a     <= '0;
            opr_b     <= '0;
            opcode    <= ADD_OP;
            rd_addr   <= '0;
            rd_we     <= 1'b0;
            illegal   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            opr_a     <= dec_legal ? rs1_val : '0;
            opr_b     <= !dec_legal ? '0 : (dec_is_op ? rs2_val : imm_val);
            opcode    <= dec_legal ? dec_op : ADD_OP;
            rd_addr   <= rd;
            rd_we     <= dec_we;
            illegal   <= !dec_legal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rv32i_id_stage.sv
// Self-checking bench for rv32i_id_stage: expected bundles queued at accept, popped on consume.
module tb_rv32i_id_stage;
    import rv32i_id_pkg::*;

    localparam int unsigned DPW = 32;

    logic           clk = 1'b0;
    logic           arst;
    logic           in_valid;
    logic           in_ready;
    logic [31:0]    in_instr;
    logic           wb_en;
    logic [4:0]     wb_addr;
    logic [DPW-1:0] wb_data;
    logic           out_valid;
    logic           out_ready;
    logic [DPW-1:0] opr_a;
    logic [DPW-1:0] opr_b;
    alu_op_t        opcode;
    logic [4:0]     rd_addr;
    logic           rd_we;
    logic           illegal;

    rv32i_id_stage #(.DPW(DPW)) dut (
        .clk(clk), .arst(arst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .opr_a(opr_a), .opr_b(opr_b), .opcode(opcode),
        .rd_addr(rd_addr), .rd_we(rd_we), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        alu_op_t     op;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, want);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b, input alu_op_t op,
                                input logic [4:0] rd, input logic we, input logic ill);
        exp_t e;
        e.a = a; e.b = b; e.op = op; e.rd = rd; e.we = we; e.ill = ill;
        return e;
    endfunction

    // Consumed bundles are compared against the oldest expectation.
    always @(negedge clk) begin
        if (!arst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_bundle", 32'd1, 32'd0);
            end else begin
                cur = exp_q.pop_front();
                chk("opr_a", opr_a, cur.a);
                chk("opr_b", opr_b, cur.b);
                chk("opcode", 32'(opcode), 32'(cur.op));
                if (!cur.ill) chk("rd_addr", 32'(rd_addr), 32'(cur.rd));
                chk("rd_we", 32'(rd_we), 32'(cur.we));
                chk("illegal", 32'(illegal), 32'(cur.ill));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] instr, input exp_t e);
        int n = 0;
        in_valid = 1'b1;
        in_instr = instr;
        #1;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            chk("issue_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
        end else begin
            exp_q.push_back(e);
            tick();
        end
    endtask

    task automatic wb(input logic [4:0] addr, input logic [31:0] data);
        wb_en   = 1'b1;
        wb_addr = addr;
        wb_data = data;
        tick();
        wb_en   = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        arst = 1'b1; in_valid = 1'b0; in_instr = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_opr_a", opr_a, 32'd0);
        chk("rst_opr_b", opr_b, 32'd0);
        chk("rst_opcode", 32'(opcode), 32'(ADD_OP));
        chk("rst_rd_addr", 32'(rd_addr), 32'd0);
        chk("rst_rd_we", 32'(rd_we), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        in_valid = 1'b0;
        tick();
        arst = 1'b0;
        #1;
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        // ADDI x1,x0,5 then dependent ADD x3,x1,x2
        issue(32'h00500093, mk(32'd0, 32'd5, ADD_OP, 5'd1, 1'b1, 1'b0));
        in_instr = 32'h002081B3;
        #1;
        chk("hazard_stall", 32'(in_ready), 32'd0);
        tick();
        chk("hazard_stall2", 32'(in_ready), 32'd0);
        wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'd5;
        #1;
`ifdef ID_BYPASS_EN
        chk("bypass_ready", 32'(in_ready), 32'd1);
        exp_q.push_back(mk(32'd5, 32'd0, ADD_OP, 5'd3, 1'b1, 1'b0));
        tick();
        wb_en = 1'b0;
        in_valid = 1'b0;
`else
        chk("wb_cycle_stall", 32'(in_ready), 32'd0);
        tick();
        wb_en = 1'b0;
        #1;
        chk("post_wb_ready", 32'(in_ready), 32'd1);
        exp_q.push_back(mk(32'd5, 32'd0, ADD_OP, 5'd3, 1'b1, 1'b0));
        tick();
        in_valid = 1'b0;
`endif
        wb(5'd3, 32'h33);
        wb(5'd1, 32'h80000000);

        // SRAI x4,x1,3
        issue(32'h4030D213, mk(32'h80000000, 32'd3, SRA_OP, 5'd4, 1'b1, 1'b0));
        in_valid = 1'b0;
        wb(5'd4, 32'd0);
        idle(2);

        // SUB x3,x1,x2 held by back-pressure for 3 cycles
        out_ready = 1'b0;
        issue(32'h402081B3, mk(32'h80000000, 32'd0, SUB_OP, 5'd3, 1'b1, 1'b0));
        in_instr = 32'h00700293;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_opcode", 32'(opcode), 32'(SUB_OP));
            chk("hold_opr_a", opr_a, 32'h80000000);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", 32'(in_ready), 32'd1);
        exp_q.push_back(mk(32'd0, 32'd7, ADD_OP, 5'd5, 1'b1, 1'b0));
        tick();
        in_valid = 1'b0;
        wb(5'd3, 32'h33);
        wb(5'd5, 32'd0);

        // Illegal encodings; SLT must not mark x3 pending
        issue(32'h0020A1B3, mk(32'd0, 32'd0, ADD_OP, 5'd0, 1'b0, 1'b1));
        in_instr = 32'h00018333;
        #1;
        chk("slt_no_pending", 32'(in_ready), 32'd1);
        issue(32'h00018333, mk(32'h33, 32'd0, ADD_OP, 5'd6, 1'b1, 1'b0));
        issue(32'h022081B3, mk(32'd0, 32'd0, ADD_OP, 5'd0, 1'b0, 1'b1));
        issue(32'h000000B7, mk(32'd0, 32'd0, ADD_OP, 5'd0, 1'b0, 1'b1));
        issue(32'h02011493, mk(32'd0, 32'd0, ADD_OP, 5'd0, 1'b0, 1'b1));
        idle(2);

        // Reset while a bundle is stalled and x1 is pending
        out_ready = 1'b0;
        issue(32'h00900093, mk(32'd0, 32'd9, ADD_OP, 5'd1, 1'b1, 1'b0));
        in_instr = 32'h002081B3;
        #1;
        chk("pre_reset_valid", 32'(out_valid), 32'd1);
        chk("pre_reset_stall", 32'(in_ready), 32'd0);
        arst = 1'b1;
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        exp_q.delete();
        in_valid = 1'b0;
        tick();
        arst = 1'b0;
        out_ready = 1'b1;
        wb(5'd2, 32'h1234);
        in_valid = 1'b1;
        in_instr = 32'h002081B3;
        #1;
        chk("post_reset_no_stall", 32'(in_ready), 32'd1);
        issue(32'h002081B3, mk(32'd0, 32'h1234, ADD_OP, 5'd3, 1'b1, 1'b0));

        // Back-to-back stream, one per cycle
        c0 = cyc;
        issue(32'h00100393, mk(32'd0, 32'd1, ADD_OP, 5'd7, 1'b1, 1'b0));
        issue(32'hFFF00413, mk(32'd0, 32'hFFFFFFFF, ADD_OP, 5'd8, 1'b1, 1'b0));
        issue(32'h00411493, mk(32'h1234, 32'd4, SLL_OP, 5'd9, 1'b1, 1'b0));
        issue(32'h0F016513, mk(32'h1234, 32'hF0, OR_OP, 5'd10, 1'b1, 1'b0));
        issue(32'hFF017593, mk(32'h1234, 32'hFFFFFFF0, AND_OP, 5'd11, 1'b1, 1'b0));
        issue(32'h00115613, mk(32'h1234, 32'd1, SRL_OP, 5'd12, 1'b1, 1'b0));
        issue(32'h000146B3, mk(32'h1234, 32'd0, XOR_OP, 5'd13, 1'b1, 1'b0));
        chk("b2b_cycles", 32'(cyc - c0), 32'd7);
        idle(3);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv32i_id_stage.md
# rv32i_id_stage

Decode/issue stage for the RV32I integer datapath. It sits directly upstream of `alu`. It accepts fetched instructions over a valid/ready handshake, decodes OP and OP-IMM instructions into `alu_op_t`, and reads operands from an internal 32×DPW register file. It tracks pending writebacks with a scoreboard and presents a registered `opr_a`/`opr_b`/`opcode` bundle to the ALU over a second valid/ready handshake.

## Interface
- `DPW`, 32, datapath width; register file is 32 × DPW.
- `clk` in 1, single clock, rising edge.
- `arst` in 1, asynchronous active-high reset.
- `in_valid` in 1, instruction available.
- `in_ready` out 1, stage accepts instruction this cycle.
- `in_instr` in 32, RV32I instruction word.
- `wb_en` in 1, writeback strobe.
- `wb_addr` in 5, writeback destination.
- `wb_data` in DPW, writeback value.
- `out_valid` out 1, issue bundle valid.
- `out_ready` in 1, downstream accepts bundle.
- `opr_a` out DPW, ALU operand A.
- `opr_b` out DPW, ALU operand B.
- `opcode` out `alu_op_t`, ALU operation.
- `rd_addr` out 5, destination register.
- `rd_we` out 1, destination write required.
- `illegal` out 1, instruction not supported.

## Operation
- Supported instructions:
  - OP (0110011): funct3/funct7 map ADD/SUB (000, f7 0x00/0x20), SLL (001), XOR (100), SRL/SRA (101, f7 0x00/0x20), OR (110), AND (111).
  - OP-IMM (0010011): same mapping except no SUBI. `opr_b` = sign-extended imm[11:0]. Shifts use `opr_b` = zero-extended imm[4:0]. SRLI/SRAI are selected by instr[30]. SLLI requires instr[31:25]=0.
- Illegal cases: SLT/SLTU, any other major opcode, and bad funct7. The bundle is still issued with `illegal`=1, `opcode`=ADD_OP, operands 0, `rd_we`=0, and no scoreboard update.
- `rd_we`=1 only for legal instructions with rd≠0.
- Register file:
  - x0 reads 0; writes to x0 are ignored.
  - Written on `wb_en` at the clock edge.
- Scoreboard, one pending bit per register:
  - Set on issue of an instruction with `rd_we`.
  - Cleared on `wb_en` to that address.
  - Same-cycle set and clear on the same register: set wins.
- Hazard: the instruction reads a pending rs1/rs2 (rs2 only for OP). A hazard deasserts `in_ready`.
- Handshake:
  - `in_ready` = (!`out_valid` || `out_ready`) && !hazard.
  - Transfer occurs when `in_valid` && `in_ready`.
  - The output holds stable while `out_valid` && !`out_ready`.

## Timing
- Accept at edge N → `out_valid`=1 and all bundle fields valid after edge N, i.e. 1-cycle latency.
- Back-to-back issue at 1 instruction/cycle when there is no hazard and `out_ready`=1.
- `out_valid` drops after the edge where the bundle is consumed and no new instruction is accepted.
- Reset values: `out_valid`=0, `opr_a`=`opr_b`=0, `opcode`=ADD_OP, `rd_addr`=0, `rd_we`=0, `illegal`=0. Scoreboard is cleared and all registers are 0.
- `in_ready` is combinational; it is 0 while `arst` is asserted.
- Reset mid-operation: the in-flight bundle is discarded and pending bits are cleared. Writebacks arriving after reset still write the register file.

## Configuration
- `ID_BYPASS_EN` defined:
  - A `wb_en` in the same cycle as a read of `wb_addr` forwards `wb_data` to the operand.
  - It also clears that register's hazard combinationally, so the dependent instruction issues in the writeback cycle.
- `ID_BYPASS_EN` undefined:
  - No forwarding; the hazard persists through the writeback cycle.
  - The dependent instruction is accepted at the earliest on the cycle after `wb_en`, reading the updated register file.

## Test plan
- Reset, then `in_instr`=0x00500093 (ADDI x1,x0,5) → next cycle: `opr_a`=0, `opr_b`=5, `opcode`=ADD_OP, `rd_addr`=1, `rd_we`=1. x1 becomes pending.
- With x1 pending, present 0x002081B3 (ADD x3,x1,x2) → `in_ready`=0.
  - Then `wb_en`, x1=5: with `ID_BYPASS_EN`, accepted that cycle with `opr_a`=5; without it, accepted one cycle later with `opr_a`=5.
- x1=0x80000000, no pending writes, 0x4030D213 (SRAI x4,x1,3) → `opcode`=SRA_OP, `opr_a`=0x80000000, `opr_b`=3. ALU result 0xF0000000.
- Present 0x402081B3 (SUB) with `out_ready`=0 for 3 cycles → the bundle holds stable with `opcode`=SUB_OP and `in_ready`=0; it advances the cycle `out_ready`=1.
- 0x0020A1B3 (SLT) → `illegal`=1, `rd_we`=0, `opcode`=ADD_OP, x3 not marked pending.
- Assert `arst` while `out_valid`=1 and x1 pending → `out_valid`=0 immediately, scoreboard cleared. After release, ADD x3,x1,x2 issues without stall.
